// File: rtl/vga_block_update_ctrl.sv
// ============================================================================
//  Module   : vga_block_update_ctrl
//  Function : Shadow/active double buffer for the movable VGA block. Updates
//             are committed once per frame at the start of vertical blanking.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module vga_block_update_ctrl #(
    parameter int H_CELLS     = 20,
    parameter int V_CELLS     = 15,
    parameter int COMMIT_LINE = 480
) (
    input  logic        pixel_clk,
    input  logic        rst,
    input  logic [10:0] hcount,
    input  logic [10:0] vcount,
    input  logic        cpu_wr,
    input  logic [8:0]  cpu_pos,
    input  logic [11:0] cpu_color,
    input  logic        step_req,
    input  logic [1:0]  step_dir,
    output logic [8:0]  pos_active,
    output logic [11:0] color_active,
    output logic        pending,
    output logic        frame_tick,
    output logic [15:0] frame_cnt,
    output logic        step_drop
);

    localparam logic [4:0]  H_MAX       = 5'(H_CELLS - 1);
    localparam logic [3:0]  V_MAX       = 4'(V_CELLS - 1);
    localparam logic [10:0] COMMIT_V    = 11'(COMMIT_LINE);
    localparam logic [8:0]  RESET_POS   = 9'h000;
    localparam logic [11:0] RESET_COLOR = 12'h00F;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    typedef enum logic [0:0] {
        CLEAN = 1'b0,
        DIRTY = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [8:0]  shadow_pos;
    logic [8:0]  shadow_pos_next;
    logic [11:0] shadow_color;
    logic [11:0] shadow_color_next;
    logic        commit;
    logic [4:0]  clamp_h;
    logic [3:0]  clamp_v;
    logic [4:0]  step_h;
    logic [3:0]  step_v;
    logic [4:0]  cur_h;
    logic [3:0]  cur_v;

    assign commit = (vcount == COMMIT_V) && (hcount == 11'd0);
    assign cur_h  = shadow_pos[8:4];
    assign cur_v  = shadow_pos[3:0];

    // Each field saturates independently so an out-of-range column never
    // disturbs a valid row and vice versa.
    always_comb begin
        clamp_h = (cpu_pos[8:4] > H_MAX) ? H_MAX : cpu_pos[8:4];
        clamp_v = (cpu_pos[3:0] > V_MAX) ? V_MAX : cpu_pos[3:0];
    end

    always_comb begin
        step_h = cur_h;
        step_v = cur_v;
        case (step_dir)
            DIR_UP:    step_v = (cur_v == 4'd0)  ? 4'd0  : cur_v - 4'd1;
            DIR_DOWN:  step_v = (cur_v >= V_MAX) ? V_MAX : cur_v + 4'd1;
            DIR_LEFT:  step_h = (cur_h == 5'd0)  ? 5'd0  : cur_h - 5'd1;
            DIR_RIGHT: step_h = (cur_h >= H_MAX) ? H_MAX : cur_h + 5'd1;
            default:   ;
        endcase
    end

    // A new request wins over the commit's return to CLEAN: the commit has
    // already taken the pre-update shadow, so the fresh value is still owed.
    always_comb begin
        state_next        = state;
        shadow_pos_next   = shadow_pos;
        shadow_color_next = shadow_color;
        if (cpu_wr) begin
            shadow_pos_next   = {clamp_h, clamp_v};
            shadow_color_next = cpu_color;
            state_next        = DIRTY;
        end else if (step_req) begin
            shadow_pos_next   = {step_h, step_v};
            state_next        = DIRTY;
        end else if (commit) begin
            state_next        = CLEAN;
        end
    end

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            state        <= CLEAN;
            shadow_pos   <= RESET_POS;
            shadow_color <= RESET_COLOR;
        end else begin
            state        <= state_next;
            shadow_pos   <= shadow_pos_next;
            shadow_color <= shadow_color_next;
        end
    end

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            pos_active   <= RESET_POS;
            color_active <= RESET_COLOR;
            frame_tick   <= 1'b0;
            frame_cnt    <= 16'd0;
            step_drop    <= 1'b0;
        end else begin
            frame_tick <= commit;
            step_drop  <= cpu_wr && step_req;
            if (commit) begin
                pos_active   <= shadow_pos;
                color_active <= shadow_color;
                frame_cnt    <= frame_cnt + 16'd1;
            end
        end
    end

    assign pending = (state == DIRTY);

endmodule

`default_nettype wire
